// File: rtl/cam_frame_ctrl_if.sv
// Signal bundle between the capture controller and its surroundings:
// camera strobes and commands in, RAM write port and status out.
interface cam_frame_ctrl_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          cmd_single;
    logic          cmd_cont;
    logic          cmd_stop;
    logic          cam_vsync;
    logic          px_valid;
    logic [DW-1:0] px_data;
    logic          vga_frame_start;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_bank;
    logic          rd_bank;
    logic          frame_done;
    logic          busy;
    logic          err_short;
    logic          err_long;
    logic [7:0]    frame_cnt;

    modport master (
        output cmd_single, cmd_cont, cmd_stop, cam_vsync, px_valid, px_data, vga_frame_start,
        input  wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_done, busy,
               err_short, err_long, frame_cnt
    );

    modport slave (
        input  cmd_single, cmd_cont, cmd_stop, cam_vsync, px_valid, px_data, vga_frame_start,
        output wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_done, busy,
               err_short, err_long, frame_cnt
    );
endinterface

// File: rtl/cam_frame_ctrl.sv
// Capture sequencer and ping-pong bank scheduler: writes one camera frame into the
// write bank, then hands that bank to the VGA reader at the reader's next frame start.
module cam_frame_ctrl #(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int AW    = 15,
    parameter int DW    = 12
) (
    input logic            clk,
    input logic            rst,
    cam_frame_ctrl_if.slave bus
);
    localparam int          NPIX     = H_RES * V_RES;
    localparam logic [AW:0] FRAME_PX = (AW + 1)'(NPIX);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SYNC,
        CAPT,
        CHECK,
        HOLD
    } state_t;

    state_t        state_reg;
    logic [AW:0]   addr_reg;
    logic          bad_reg;
    logic          pending_reg;
    logic          cont_reg;
    logic          vsync_reg;

    logic          wr_en_reg;
    logic [AW-1:0] wr_addr_reg;
    logic [DW-1:0] wr_data_reg;
    logic          wr_bank_reg;
    logic          rd_bank_reg;
    logic          frame_done_reg;
    logic          err_short_reg;
    logic          err_long_reg;
    logic [7:0]    frame_cnt_reg;

    logic          vs_fall;
    logic          vs_rise;

    assign vs_fall = vsync_reg & ~bus.cam_vsync;
    assign vs_rise = ~vsync_reg & bus.cam_vsync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            bad_reg        <= 1'b0;
            pending_reg    <= 1'b0;
            cont_reg       <= 1'b0;
            vsync_reg      <= 1'b1;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            wr_bank_reg    <= 1'b1;
            rd_bank_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            err_short_reg  <= 1'b0;
            err_long_reg   <= 1'b0;
            frame_cnt_reg  <= 8'd0;
        end else begin
            vsync_reg      <= bus.cam_vsync;
            wr_en_reg      <= 1'b0;
            frame_done_reg <= 1'b0;

            // Swap only ever happens while no capture is writing, because a capture
            // starts only with pending clear and pending is set only at its end.
            if (bus.vga_frame_start && pending_reg) begin
                rd_bank_reg <= wr_bank_reg;
                wr_bank_reg <= ~wr_bank_reg;
                pending_reg <= 1'b0;
            end

            if (bus.cmd_stop) begin
                state_reg <= IDLE;
                cont_reg  <= 1'b0;
            end else begin
                if (state_reg != IDLE) begin
                    if (bus.cmd_cont) begin
                        cont_reg <= 1'b1;
                    end else if (bus.cmd_single) begin
                        cont_reg <= 1'b0;
                    end
                end

                case (state_reg)
                    IDLE: begin
                        if (bus.cmd_single || bus.cmd_cont) begin
                            state_reg     <= ARM;
                            cont_reg      <= bus.cmd_cont;
                            err_short_reg <= 1'b0;
                            err_long_reg  <= 1'b0;
                        end
                    end

                    ARM: begin
                        // Require blanking before syncing so a frame already in
                        // progress is never captured from its middle.
                        if (pending_reg) begin
                            state_reg <= HOLD;
                        end else if (bus.cam_vsync) begin
                            state_reg <= SYNC;
                        end
                    end

                    SYNC: begin
                        if (vs_fall) begin
                            state_reg <= CAPT;
                            addr_reg  <= '0;
                            bad_reg   <= 1'b0;
                        end
                    end

                    CAPT: begin
                        if (bus.px_valid) begin
                            if (addr_reg < FRAME_PX) begin
                                wr_en_reg   <= 1'b1;
                                wr_addr_reg <= addr_reg[AW-1:0];
                                wr_data_reg <= bus.px_data;
                                addr_reg    <= addr_reg + 1'b1;
                            end else begin
                                err_long_reg <= 1'b1;
                                bad_reg      <= 1'b1;
                            end
                        end
                        if (vs_rise) begin
                            state_reg <= CHECK;
                        end
                    end

                    CHECK: begin
                        if ((addr_reg == FRAME_PX) && !bad_reg) begin
                            pending_reg    <= 1'b1;
                            frame_done_reg <= 1'b1;
                            frame_cnt_reg  <= frame_cnt_reg + 8'd1;
                        end else if (addr_reg < FRAME_PX) begin
                            err_short_reg <= 1'b1;
                        end
                        state_reg <= cont_reg ? ARM : IDLE;
                    end

                    HOLD: begin
                        if (!pending_reg) begin
                            state_reg <= ARM;
                        end
                    end

                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.wr_en      = wr_en_reg;
    assign bus.wr_addr    = wr_addr_reg;
    assign bus.wr_data    = wr_data_reg;
    assign bus.wr_bank    = wr_bank_reg;
    assign bus.rd_bank    = rd_bank_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.err_short  = err_short_reg;
    assign bus.err_long   = err_long_reg;
    assign bus.frame_cnt  = frame_cnt_reg;
endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Bench for cam_frame_ctrl: a 4x2 instance driven by a frame-level vector table and
// hand sequences, plus a full 160x120 instance for one complete frame.
module tb_cam_frame_ctrl;
    localparam int AW = 15;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cam_frame_ctrl_if #(.AW(AW), .DW(DW)) bus_s ();
    cam_frame_ctrl_if #(.AW(AW), .DW(DW)) bus_f ();

    cam_frame_ctrl #(.H_RES(4), .V_RES(2), .AW(AW), .DW(DW)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    cam_frame_ctrl #(.H_RES(160), .V_RES(120), .AW(AW), .DW(DW)) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Small-instance monitor: writes must be sequential within a frame with data 0x300+index.
    int s_wr_cnt = 0;
    int s_idx = 0;
    int s_done_cnt = 0;
    int s_last_bank = -1;
    int s_bank_viol = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_s.wr_en) begin
                chk("s_wr_addr", int'(bus_s.wr_addr), s_idx);
                chk("s_wr_data", int'(bus_s.wr_data), 'h300 + s_idx);
                s_last_bank = int'(bus_s.wr_bank);
                s_idx++;
                s_wr_cnt++;
            end
            if (bus_s.frame_done) s_done_cnt++;
            if (bus_s.wr_bank == bus_s.rd_bank) s_bank_viol++;
        end
    end

    int f_wr_cnt = 0;
    int f_last = -1;
    int f_err = 0;
    int f_done = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_f.wr_en) begin
                if (int'(bus_f.wr_addr) != f_wr_cnt) f_err++;
                if (bus_f.wr_data != 12'(f_wr_cnt)) f_err++;
                f_last = int'(bus_f.wr_addr);
                f_wr_cnt++;
            end
            if (bus_f.frame_done) f_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 single, 1 cont, 2 stop, 3 vga_frame_start
    task automatic pulse(input int which);
        case (which)
            0: bus_s.cmd_single = 1'b1;
            1: bus_s.cmd_cont = 1'b1;
            2: bus_s.cmd_stop = 1'b1;
            default: bus_s.vga_frame_start = 1'b1;
        endcase
        tick();
        bus_s.cmd_single = 1'b0;
        bus_s.cmd_cont = 1'b0;
        bus_s.cmd_stop = 1'b0;
        bus_s.vga_frame_start = 1'b0;
    endtask

    // Blanking, frame start, n_px pixels with one idle cycle between, frame end, blanking.
    task automatic frame(input int n_px);
        s_idx = 0;
        bus_s.cam_vsync = 1'b1;
        repeat (3) tick();
        bus_s.cam_vsync = 1'b0;
        tick();
        for (int k = 0; k < n_px; k++) begin
            bus_s.px_valid = 1'b1;
            bus_s.px_data = 12'(12'h300 + k);
            tick();
            bus_s.px_valid = 1'b0;
            tick();
        end
        repeat (2) tick();
        bus_s.cam_vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wr_en"}, int'(bus_s.wr_en), 0);
        chk({tag, "_wr_addr"}, int'(bus_s.wr_addr), 0);
        chk({tag, "_wr_data"}, int'(bus_s.wr_data), 0);
        chk({tag, "_wr_bank"}, int'(bus_s.wr_bank), 1);
        chk({tag, "_rd_bank"}, int'(bus_s.rd_bank), 0);
        chk({tag, "_frame_done"}, int'(bus_s.frame_done), 0);
        chk({tag, "_busy"}, int'(bus_s.busy), 0);
        chk({tag, "_err_short"}, int'(bus_s.err_short), 0);
        chk({tag, "_err_long"}, int'(bus_s.err_long), 0);
        chk({tag, "_frame_cnt"}, int'(bus_s.frame_cnt), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    typedef struct {
        int n_px;
        bit vga_after;
        int exp_writes;
        int exp_wbank;
        int exp_done;
        int exp_short;
        int exp_long;
        int exp_cnt;
        int exp_rd;
        int exp_wr;
        int exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // Every record issues cmd_single, runs one frame, optionally pulses vga_frame_start.
        vecs[0] = '{8, 1'b1, 8, 1, 1, 0, 0, 1, 1, 0, 0};  // good frame, published
        vecs[1] = '{7, 1'b1, 7, 0, 0, 1, 0, 1, 1, 0, 0};  // short frame, discarded
        vecs[2] = '{9, 1'b1, 8, 0, 0, 0, 1, 1, 1, 0, 0};  // long frame, 8 writes only
        vecs[3] = '{8, 1'b0, 8, 0, 1, 0, 0, 2, 1, 0, 0};  // good frame left pending
        vecs[4] = '{0, 1'b1, 0, 0, 0, 0, 0, 2, 0, 1, 1};  // held by pending, then swap
        vecs[5] = '{8, 1'b1, 8, 1, 1, 0, 0, 3, 1, 0, 0};  // cmd while busy ignored

        rst = 1'b1;
        bus_s.cmd_single = 1'b0;
        bus_s.cmd_cont = 1'b0;
        bus_s.cmd_stop = 1'b0;
        bus_s.cam_vsync = 1'b1;
        bus_s.px_valid = 1'b0;
        bus_s.px_data = '0;
        bus_s.vga_frame_start = 1'b0;
        bus_f.cmd_single = 1'b0;
        bus_f.cmd_cont = 1'b0;
        bus_f.cmd_stop = 1'b0;
        bus_f.cam_vsync = 1'b1;
        bus_f.px_valid = 1'b0;
        bus_f.px_data = '0;
        bus_f.vga_frame_start = 1'b0;
        repeat (2) tick();
        check_reset("rst0");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            s_wr_cnt = 0;
            s_done_cnt = 0;
            s_last_bank = -1;
            pulse(0);
            frame(vecs[i].n_px);
            if (vecs[i].vga_after) pulse(3);
            repeat (3) tick();
            chk($sformatf("v%0d_writes", i), s_wr_cnt, vecs[i].exp_writes);
            if (vecs[i].exp_writes > 0)
                chk($sformatf("v%0d_wbank", i), s_last_bank, vecs[i].exp_wbank);
            chk($sformatf("v%0d_done", i), s_done_cnt, vecs[i].exp_done);
            chk($sformatf("v%0d_err_short", i), int'(bus_s.err_short), vecs[i].exp_short);
            chk($sformatf("v%0d_err_long", i), int'(bus_s.err_long), vecs[i].exp_long);
            chk($sformatf("v%0d_frame_cnt", i), int'(bus_s.frame_cnt), vecs[i].exp_cnt);
            chk($sformatf("v%0d_rd_bank", i), int'(bus_s.rd_bank), vecs[i].exp_rd);
            chk($sformatf("v%0d_wr_bank", i), int'(bus_s.wr_bank), vecs[i].exp_wr);
            chk($sformatf("v%0d_busy", i), int'(bus_s.busy), vecs[i].exp_busy);
        end

        // Continuous mode with no VGA frame start: only the first frame is written.
        do_reset();
        s_wr_cnt = 0;
        s_done_cnt = 0;
        pulse(1);
        repeat (3) frame(8);
        chk("cont_done", s_done_cnt, 1);
        chk("cont_writes", s_wr_cnt, 8);
        chk("cont_wbank", s_last_bank, 1);
        chk("cont_busy_hold", int'(bus_s.busy), 1);
        bus_s.cam_vsync = 1'b0;
        repeat (4) tick();
        pulse(3);
        repeat (2) tick();
        chk("cont_rd_bank", int'(bus_s.rd_bank), 1);
        chk("cont_wr_bank", int'(bus_s.wr_bank), 0);
        for (int k = 0; k < 3; k++) begin
            bus_s.px_valid = 1'b1;
            tick();
        end
        bus_s.px_valid = 1'b0;
        tick();
        chk("cont_no_midframe_writes", s_wr_cnt, 8);
        frame(8);
        chk("cont_resume_writes", s_wr_cnt, 16);
        chk("cont_resume_wbank", s_last_bank, 0);
        chk("cont_resume_done", s_done_cnt, 2);
        chk("cont_frame_cnt", int'(bus_s.frame_cnt), 2);
        pulse(2);
        tick();
        chk("cont_stop_busy", int'(bus_s.busy), 0);

        // Arm in the middle of an active frame: must wait for a full blanking.
        pulse(3);
        tick();
        chk("mid_rd_bank", int'(bus_s.rd_bank), 0);
        s_wr_cnt = 0;
        s_done_cnt = 0;
        s_idx = 0;
        bus_s.cam_vsync = 1'b0;
        tick();
        bus_s.px_valid = 1'b1;
        bus_s.cmd_single = 1'b1;
        tick();
        bus_s.cmd_single = 1'b0;
        repeat (3) tick();
        bus_s.px_valid = 1'b0;
        tick();
        chk("mid_no_writes", s_wr_cnt, 0);
        chk("mid_busy", int'(bus_s.busy), 1);
        frame(8);
        chk("mid_writes", s_wr_cnt, 8);
        chk("mid_wbank", s_last_bank, 1);
        chk("mid_done", s_done_cnt, 1);
        chk("mid_frame_cnt", int'(bus_s.frame_cnt), 3);
        pulse(3);
        tick();
        chk("mid_swap_rd", int'(bus_s.rd_bank), 1);

        // cmd_stop after four pixels.
        s_wr_cnt = 0;
        s_done_cnt = 0;
        s_idx = 0;
        pulse(0);
        bus_s.cam_vsync = 1'b1;
        repeat (3) tick();
        bus_s.cam_vsync = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus_s.px_valid = 1'b1;
            bus_s.px_data = 12'(12'h300 + k);
            tick();
        end
        bus_s.px_valid = 1'b0;
        pulse(2);
        repeat (2) tick();
        bus_s.cam_vsync = 1'b1;
        repeat (3) tick();
        chk("stop_busy", int'(bus_s.busy), 0);
        chk("stop_writes", s_wr_cnt, 4);
        chk("stop_done", s_done_cnt, 0);
        chk("stop_frame_cnt", int'(bus_s.frame_cnt), 3);
        pulse(3);
        tick();
        chk("stop_rd_bank", int'(bus_s.rd_bank), 1);
        chk("stop_wr_bank", int'(bus_s.wr_bank), 0);

        // Reset after four pixels.
        s_wr_cnt = 0;
        s_done_cnt = 0;
        s_idx = 0;
        pulse(0);
        repeat (3) tick();
        bus_s.cam_vsync = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus_s.px_valid = 1'b1;
            bus_s.px_data = 12'(12'h300 + k);
            tick();
        end
        bus_s.px_valid = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        check_reset("midrst");
        tick();
        rst = 1'b0;
        for (int k = 4; k < 8; k++) begin
            bus_s.px_valid = 1'b1;
            tick();
        end
        bus_s.px_valid = 1'b0;
        bus_s.cam_vsync = 1'b1;
        repeat (3) tick();
        chk("rst_writes", s_wr_cnt, 4);
        chk("rst_done", s_done_cnt, 0);
        chk("rst_busy", int'(bus_s.busy), 0);
        chk("bank_conflicts", s_bank_viol, 0);

        // Full-size 160x120 frame on the second instance.
        bus_f.cmd_single = 1'b1;
        tick();
        bus_f.cmd_single = 1'b0;
        repeat (3) tick();
        bus_f.cam_vsync = 1'b0;
        tick();
        for (int k = 0; k < 19200; k++) begin
            bus_f.px_valid = 1'b1;
            bus_f.px_data = 12'(k);
            tick();
        end
        bus_f.px_valid = 1'b0;
        repeat (2) tick();
        bus_f.cam_vsync = 1'b1;
        repeat (4) tick();
        chk("full_writes", f_wr_cnt, 19200);
        chk("full_last_addr", f_last, 19199);
        chk("full_seq_errors", f_err, 0);
        chk("full_done", f_done, 1);
        chk("full_frame_cnt", int'(bus_f.frame_cnt), 1);
        chk("full_err_short", int'(bus_f.err_short), 0);
        chk("full_err_long", int'(bus_f.err_long), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
